// File: rtl/core_biu_arbiter_if.sv
// -----------------------------------------------------------------------------
// core_biu_arbiter_if
//   Bundles the three channels the core BIU arbiter sits between:
//     ifu_*  : instruction-fetch request/response (plus pipeline flush)
//     lsu_*  : load/store request/response
//     mem_*  : the single shared memory port
//   Modports:
//     slave  : the arbiter's view (it serves IFU/LSU and drives mem_req_*)
//     master : the surrounding core/memory view (drives requests, mem ready
//              and mem responses; observes everything else)
//   Parameters: ADDR_W address width, DATA_W data width (strobe = DATA_W/8).
// -----------------------------------------------------------------------------
interface core_biu_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // fetch side
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_flush;
  logic              ifu_rsp_valid;
  logic [DATA_W-1:0] ifu_rsp_data;
  logic              ifu_rsp_err;

  // load/store side
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_wen;
  logic [STRB_W-1:0] lsu_req_wstrb;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic              lsu_rsp_valid;
  logic [DATA_W-1:0] lsu_rsp_data;
  logic              lsu_rsp_err;

  // shared memory port
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [STRB_W-1:0] mem_req_wstrb;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              mem_rsp_err;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_flush,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wstrb, lsu_req_wdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_flush,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wstrb, lsu_req_wdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );
endinterface

// File: rtl/core_biu_arbiter.sv
// -----------------------------------------------------------------------------
// core_biu_arbiter
//   Shares the core's single memory port between instruction fetch (IFU) and
//   load/store (LSU). One transaction in flight at a time:
//     IDLE -> accept one request -> REQ (mem_req_valid until mem_req_ready)
//          -> RSP (wait mem_rsp_valid, route it to the owner) -> IDLE
//   LSU wins arbitration unless IFU has been passed over STARVE_LIMIT times
//   in a row while waiting. An IFU flush during an IFU-owned transaction lets
//   the memory access finish but swallows its response.
//
//   Parameters: ADDR_W, DATA_W (strobe = DATA_W/8), STARVE_LIMIT (>= 1).
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : core_biu_arbiter_if.slave (ifu_*, lsu_*, mem_* channels)
//     busy : high whenever a transaction is in flight (state != IDLE)
// -----------------------------------------------------------------------------
module core_biu_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  core_biu_arbiter_if.slave   bus,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  typedef enum logic       {OWN_IFU, OWN_LSU} owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  state_t             state_q, state_d;
  owner_t             owner_q, owner_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  mem_req_t           req_q, req_d;

  logic ifu_elig;
  logic force_ifu;
  logic grant_ifu;
  logic grant_lsu;
  logic kill_ifu_rsp;

  // ---------------------------------------------------------------------------
  // Arbitration. Grants are qualified with !rst so both readies read 0 while
  // reset is held, even though the state register is already IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    ifu_elig  = bus.ifu_req_valid & ~bus.ifu_flush;
    force_ifu = ifu_elig & (starve_q == CNT_MAX);
    grant_lsu = (state_q == IDLE) & ~rst & bus.lsu_req_valid & ~force_ifu;
    grant_ifu = (state_q == IDLE) & ~rst & ifu_elig &
                (~bus.lsu_req_valid | force_ifu);
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    drop_d   = drop_q;
    starve_d = starve_q;
    req_d    = req_q;

    case (state_q)
      IDLE: begin
        if (grant_lsu) begin
          req_d   = '{addr:  bus.lsu_req_addr,
                      wen:   bus.lsu_req_wen,
                      wstrb: bus.lsu_req_wstrb,
                      wdata: bus.lsu_req_wdata};
          owner_d = OWN_LSU;
          state_d = REQ;
          // Passed-over count uses the raw IFU valid, flushed or not.
          if (bus.ifu_req_valid && (starve_q != CNT_MAX))
            starve_d = starve_q + 1'b1;
        end else if (grant_ifu) begin
          req_d    = '{addr:  bus.ifu_req_addr,
                       wen:   1'b0,
                       wstrb: '0,
                       wdata: '0};
          owner_d  = OWN_IFU;
          state_d  = REQ;
          starve_d = '0;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) state_d = RSP;
      end
      RSP: begin
        if (bus.mem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush against an in-flight fetch marks its response as stale; the
    // memory transaction itself still runs to completion.
    if ((state_q != IDLE) && (owner_q == OWN_IFU) && bus.ifu_flush)
      drop_d = 1'b1;
    // Leaving RSP wipes the stale mark so the next fetch is delivered.
    if (state_d == IDLE)
      drop_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IFU;
      drop_q   <= 1'b0;
      starve_q <= '0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
      req_q    <= req_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // A flush arriving in the same cycle as the response must also kill it,
  // since drop_q only reflects flushes from earlier cycles.
  assign kill_ifu_rsp = drop_q | bus.ifu_flush;

  assign bus.ifu_req_ready = grant_ifu;
  assign bus.lsu_req_ready = grant_lsu;

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = req_q.addr;
  assign bus.mem_req_wen   = req_q.wen;
  assign bus.mem_req_wstrb = req_q.wstrb;
  assign bus.mem_req_wdata = req_q.wdata;

  assign bus.ifu_rsp_valid = (state_q == RSP) & (owner_q == OWN_IFU) &
                             bus.mem_rsp_valid & ~kill_ifu_rsp;
  assign bus.lsu_rsp_valid = (state_q == RSP) & (owner_q == OWN_LSU) &
                             bus.mem_rsp_valid & ~drop_q;

  // Data/err are only meaningful alongside the matching rsp_valid.
  assign bus.ifu_rsp_data  = bus.mem_rsp_data;
  assign bus.ifu_rsp_err   = bus.mem_rsp_err;
  assign bus.lsu_rsp_data  = bus.mem_rsp_data;
  assign bus.lsu_rsp_err   = bus.mem_rsp_err;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_core_biu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_biu_arbiter
//   Scenario tasks drive the IFU/LSU/memory sides of core_biu_arbiter.
//   Expected memory requests and responses are queued as stimulus is driven;
//   a negedge monitor pops and compares them as the DUT produces them, and
//   records the grant order. Tasks also check cycle-level behaviour inline.
// -----------------------------------------------------------------------------
module tb_core_biu_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wen;
    logic [3:0]    wstrb;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  core_biu_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  core_biu_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  req_t sb_req[$];
  rsp_t sb_ifu[$];
  rsp_t sb_lsu[$];
  bit   grant_log[$];   // 1 = LSU granted, 0 = IFU granted
  int   checks = 0;
  int   errors = 0;
  int   ifu_pulses = 0;
  int   lsu_pulses = 0;

  req_t mon_act, mon_exp;
  rsp_t mon_rsp, mon_rexp;

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (bus.ifu_req_valid && bus.ifu_req_ready) grant_log.push_back(1'b0);
    if (bus.lsu_req_valid && bus.lsu_req_ready) grant_log.push_back(1'b1);

    if (bus.mem_req_valid && bus.mem_req_ready) begin
      checks++;
      mon_act = '{bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wstrb, bus.mem_req_wdata};
      if (sb_req.size() == 0) begin
        errors++;
        $display("FAIL mem_req_unexpected got %h want none", mon_act);
      end else begin
        mon_exp = sb_req.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL mem_req_fields got %h want %h", mon_act, mon_exp);
        end
      end
    end

    if (bus.ifu_rsp_valid) begin
      ifu_pulses++;
      checks++;
      mon_rsp = '{bus.ifu_rsp_data, bus.ifu_rsp_err};
      if (sb_ifu.size() == 0) begin
        errors++;
        $display("FAIL ifu_rsp_unexpected got %h want none", mon_rsp);
      end else begin
        mon_rexp = sb_ifu.pop_front();
        if (mon_rsp !== mon_rexp) begin
          errors++;
          $display("FAIL ifu_rsp got %h want %h", mon_rsp, mon_rexp);
        end
      end
    end

    if (bus.lsu_rsp_valid) begin
      lsu_pulses++;
      checks++;
      mon_rsp = '{bus.lsu_rsp_data, bus.lsu_rsp_err};
      if (sb_lsu.size() == 0) begin
        errors++;
        $display("FAIL lsu_rsp_unexpected got %h want none", mon_rsp);
      end else begin
        mon_rexp = sb_lsu.pop_front();
        if (mon_rsp !== mon_rexp) begin
          errors++;
          $display("FAIL lsu_rsp got %h want %h", mon_rsp, mon_rexp);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking)
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_req_addr  = '0;
    bus.ifu_flush     = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_addr  = '0;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_wstrb = '0;
    bus.lsu_req_wdata = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rsp_err   = 1'b0;
  endtask

  // Called in the REQ cycle; returns at the start of the following IDLE cycle.
  task automatic run_mem(input int stall, input logic [DW-1:0] d, input logic e);
    for (int i = 0; i < stall; i++) begin
      bus.mem_req_ready = 1'b0;
      cyc();
    end
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = d;
    bus.mem_rsp_err   = e;
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_err   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios (each starts and ends just after a rising edge, FSM in IDLE)
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    #1 rst = 1'b1;
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    #1;
    checks++;
    if (bus.ifu_req_ready !== 1'b0 || bus.lsu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b%b want 00", bus.ifu_req_ready, bus.lsu_req_ready);
    end
    checks++;
    if (busy !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_valid got %b%b want 00", busy, bus.mem_req_valid);
    end
    checks++;
    if ({bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wstrb, bus.mem_req_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem_fields got %h want 0", bus.mem_req_addr);
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h8000_0000;
    sb_req.push_back('{32'h8000_0000, 1'b0, 4'h0, 32'h0});
    @(negedge clk);
    checks++;
    if (bus.ifu_req_ready !== 1'b1 || bus.lsu_req_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_accept got rdy %b%b busy %b want 10 0", bus.ifu_req_ready, bus.lsu_req_ready, busy);
    end
    cyc();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_req_addr  = '0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_req_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req_cycle got valid %b busy %b want 1 1", bus.mem_req_valid, busy);
    end
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_0013;
    sb_ifu.push_back('{32'h0000_0013, 1'b0});
    @(negedge clk);
    checks++;
    if (bus.ifu_rsp_valid !== 1'b1 || bus.lsu_rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_rsp_cycle got ifu %b lsu %b busy %b want 1 0 1", bus.ifu_rsp_valid, bus.lsu_rsp_valid, busy);
    end
    cyc();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.ifu_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done got busy %b rsp %b want 0 0", busy, bus.ifu_rsp_valid);
    end
    cyc();
  endtask

  task automatic test_contention();
    grant_log.delete();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h0000_0100;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h0000_0200;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_wstrb = 4'hF;
    bus.lsu_req_wdata = 32'hDEAD_BEEF;
    sb_req.push_back('{32'h0000_0200, 1'b1, 4'hF, 32'hDEAD_BEEF});
    sb_req.push_back('{32'h0000_0100, 1'b0, 4'h0, 32'h0});
    sb_lsu.push_back('{32'h0000_0011, 1'b0});
    sb_ifu.push_back('{32'h0000_0022, 1'b0});
    @(negedge clk);
    checks++;
    if (bus.lsu_req_ready !== 1'b1 || bus.ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL contention_first got lsu %b ifu %b want 1 0", bus.lsu_req_ready, bus.ifu_req_ready);
    end
    cyc();
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_wen   = 1'b0;
    run_mem(0, 32'h0000_0011, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL contention_second got ifu_ready %b want 1", bus.ifu_req_ready);
    end
    cyc();
    bus.ifu_req_valid = 1'b0;
    run_mem(1, 32'h0000_0022, 1'b0);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] !== 1'b1 || grant_log[1] !== 1'b0) begin
      errors++;
      $display("FAIL contention_order got %0d grants want LSU,IFU", grant_log.size());
    end
  endtask

  task automatic test_starvation();
    bit exp_order[6];
    int bad;
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    grant_log.delete();
    for (int i = 0; i < 6; i++) begin
      if (exp_order[i]) begin
        sb_req.push_back('{32'h0000_0300, 1'b1, 4'h3, 32'h0000_0055});
        sb_lsu.push_back('{32'h0000_1000 + 32'(i), 1'b0});
      end else begin
        sb_req.push_back('{32'h0000_0400, 1'b0, 4'h0, 32'h0});
        sb_ifu.push_back('{32'h0000_1000 + 32'(i), 1'b0});
      end
    end
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h0000_0400;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h0000_0300;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_wstrb = 4'h3;
    bus.lsu_req_wdata = 32'h0000_0055;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 5) begin
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
      end
      run_mem(0, 32'h0000_1000 + 32'(i), 1'b0);
    end
    bad = (grant_log.size() != 6) ? 1 : 0;
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      if (grant_log[i] !== exp_order[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL starve_order got %0d grants with %0d wrong want L,L,L,L,I,L", grant_log.size(), bad);
    end
    bus.lsu_req_wen = 1'b0;
  endtask

  task automatic test_flush();
    int p;
    // flush in IDLE blocks IFU acceptance for that cycle only
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h0000_0500;
    bus.ifu_flush     = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_block got ready %b want 0", bus.ifu_req_ready);
    end
    cyc();
    bus.ifu_flush = 1'b0;
    sb_req.push_back('{32'h0000_0500, 1'b0, 4'h0, 32'h0});
    @(negedge clk);
    checks++;
    if (bus.ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_release got ready %b want 1", bus.ifu_req_ready);
    end
    cyc();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    // RSP: flush pulse before the response
    bus.mem_req_ready = 1'b0;
    bus.ifu_flush     = 1'b1;
    cyc();
    bus.ifu_flush     = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_ABCD;
    p = ifu_pulses;
    @(negedge clk);
    checks++;
    if (bus.ifu_rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_drop got rsp %b busy %b want 0 1", bus.ifu_rsp_valid, busy);
    end
    cyc();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ifu_pulses != p) begin
      errors++;
      $display("FAIL flush_return got busy %b pulses %0d want 0 %0d", busy, ifu_pulses, p);
    end
    // flush in the same cycle as the response
    cyc();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h0000_0504;
    sb_req.push_back('{32'h0000_0504, 1'b0, 4'h0, 32'h0});
    cyc();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_5555;
    bus.ifu_flush     = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ifu_rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_same_cycle got rsp %b busy %b want 0 1", bus.ifu_rsp_valid, busy);
    end
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.ifu_flush     = 1'b0;
    // a fresh fetch after the flush is delivered normally
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h0000_0508;
    sb_req.push_back('{32'h0000_0508, 1'b0, 4'h0, 32'h0});
    sb_ifu.push_back('{32'h0000_1234, 1'b0});
    p = ifu_pulses;
    cyc();
    bus.ifu_req_valid = 1'b0;
    run_mem(0, 32'h0000_1234, 1'b0);
    checks++;
    if (ifu_pulses != p + 1) begin
      errors++;
      $display("FAIL flush_refetch got pulses %0d want %0d", ifu_pulses, p + 1);
    end
  endtask

  task automatic test_backpressure_reset();
    req_t exp_r;
    req_t act_r;
    exp_r = '{32'h0000_0600, 1'b1, 4'h5, 32'hCAFE_0001};
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h0000_0600;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_wstrb = 4'h5;
    bus.lsu_req_wdata = 32'hCAFE_0001;
    sb_req.push_back(exp_r);
    cyc();
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_addr  = 32'hFFFF_FFFF;
    bus.lsu_req_wstrb = 4'hA;
    bus.lsu_req_wdata = 32'h0;
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      act_r = '{bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wstrb, bus.mem_req_wdata};
      checks++;
      if (bus.mem_req_valid !== 1'b1 || act_r !== exp_r) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid %b %h want 1 %h", i, bus.mem_req_valid, act_r, exp_r);
      end
      cyc();
    end
    bus.lsu_req_wen   = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    // RSP: reset before the response arrives
    bus.mem_req_ready = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_0077;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.ifu_req_ready !== 1'b0 ||
        bus.lsu_req_ready !== 1'b0 || bus.ifu_rsp_valid !== 1'b0 || bus.lsu_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_txn got busy %b mv %b rdy %b%b rsp %b%b want all 0", busy,
               bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid);
    end
    checks++;
    if (bus.mem_req_addr !== '0 || bus.mem_req_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mid_fields got %h %h want 0 0", bus.mem_req_addr, bus.mem_req_wdata);
    end
    cyc();
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ifu_rsp_valid !== 1'b0 || bus.lsu_rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_rsp_ignored got rsp %b%b busy %b want 00 0", bus.ifu_rsp_valid, bus.lsu_rsp_valid, busy);
    end
    cyc();
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_error();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h0000_0700;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_wstrb = 4'h0;
    bus.lsu_req_wdata = 32'h0;
    sb_req.push_back('{32'h0000_0700, 1'b0, 4'h0, 32'h0});
    sb_lsu.push_back('{32'h0000_0BAD, 1'b1});
    cyc();
    bus.lsu_req_valid = 1'b0;
    bus.ifu_flush     = 1'b1;   // LSU-owned: must not affect delivery
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_0BAD;
    bus.mem_rsp_err   = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.lsu_rsp_valid !== 1'b1 || bus.lsu_rsp_err !== 1'b1 || bus.ifu_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_passthrough got valid %b err %b ifu %b want 1 1 0",
               bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.ifu_rsp_valid);
    end
    cyc();
    clear_inputs();
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_flush();
    test_backpressure_reset();
    test_error();
    checks++;
    if (sb_req.size() != 0 || sb_ifu.size() != 0 || sb_lsu.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got req %0d ifu %0d lsu %0d want 0 0 0",
               sb_req.size(), sb_ifu.size(), sb_lsu.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_biu_arbiter.md
# core_biu_arbiter

Two-requester arbiter sharing the core's single memory port between instruction fetch (IFU) and load/store (LSU, inside the EXU). It accepts one request at a time, issues it on the memory request channel, and routes the response back to its owner. LSU has priority, with a starvation guard for IFU. A pipeline-flush input drops stale fetch responses.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- STARVE_LIMIT, 4, consecutive LSU grants with IFU waiting before IFU is forced; must be ≥1
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ifu_req_valid / ifu_req_ready  in / out  1  fetch request handshake
- ifu_req_addr  in  ADDR_W  fetch address
- ifu_flush  in  1  pipeline flush; discards IFU traffic
- ifu_rsp_valid  out  1  fetch response pulse
- ifu_rsp_data  out  DATA_W  fetch response data
- ifu_rsp_err  out  1  fetch response error
- lsu_req_valid / lsu_req_ready  in / out  1  data request handshake
- lsu_req_addr  in  ADDR_W  data address
- lsu_req_wen  in  1  1 = store
- lsu_req_wstrb  in  DATA_W/8  byte strobes
- lsu_req_wdata  in  DATA_W  store data
- lsu_rsp_valid  out  1  data response pulse
- lsu_rsp_data  out  DATA_W  data response data
- lsu_rsp_err  out  1  data response error
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request ready
- mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata  out  ADDR_W / 1 / DATA_W/8 / DATA_W  registered memory request fields
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_data  in  DATA_W  memory response data
- mem_rsp_err  in  1  memory response error
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, REQ, RSP. Owner register: IFU or LSU. Flag: drop.
- **IDLE**
  - Arbitrate among lsu_req_valid and (ifu_req_valid & !ifu_flush).
  - LSU wins unless starve_cnt == STARVE_LIMIT and IFU is eligible.
  - The winner's req_ready = 1 combinationally; the loser's req_ready = 0.
  - On accept: capture addr/wen/wstrb/wdata (IFU: wen = 0, wstrb = 0, wdata = 0), set owner, go to REQ.
  - With no eligible request, both req_ready = 0.
- **REQ**
  - mem_req_valid = 1; fields are held stable from registers.
  - On mem_req_ready: go to RSP.
- **RSP**
  - On mem_rsp_valid: go to IDLE.
  - The owner's rsp_valid = mem_rsp_valid & !drop. rsp_data/err pass through combinationally.
  - The non-owner's rsp_valid = 0.
- mem_rsp_valid in IDLE or REQ is ignored, as are stray or late responses.
- **Starvation counter**, width $clog2(STARVE_LIMIT+1), saturating:
  - Increments on an LSU grant while ifu_req_valid = 1.
  - Clears on any IFU grant.
  - Holds otherwise.
- **Flush**
  - ifu_flush in REQ/RSP with owner = IFU sets drop. The memory transaction still completes; the response is consumed and not forwarded.
  - drop clears on entry to IDLE.
  - Flush with owner = LSU has no effect.
  - Flush in IDLE blocks IFU acceptance that cycle only.
- The rsp_data/err outputs are don't-care while the corresponding rsp_valid = 0.

## Timing
- Reset (async, immediate):
  - State = IDLE, owner = IFU, drop = 0, starve_cnt = 0.
  - mem_req_* registers = 0.
  - All ready/valid outputs = 0 and busy = 0, including the combinational ready outputs while rst = 1.
- Reset mid-transaction aborts to IDLE; a subsequent mem_rsp_valid is ignored.
- Accept in cycle N → mem_req_valid from N+1.
- Minimum round trip with mem_req_ready = 1 at N+1 and mem_rsp_valid at N+2:
  - Response delivered at N+2 (same cycle as mem_rsp_valid).
  - Next accept earliest N+3.
- The memory must respond at least one cycle after its request handshake.
- mem_req_valid never deasserts before mem_req_ready.
- Only one outstanding transaction exists at any time.
- ifu_flush and mem_rsp_valid in the same RSP cycle with owner IFU: the response is dropped (rsp_valid gating uses drop | ifu_flush).

## Test plan
- **Single fetch:** ifu_req addr 0x8000_0000; mem ready at N+1; rsp 0x0000_0013 at N+2 → ifu_rsp_valid pulse at N+2 with data 0x13; busy high N+1..N+2; lsu_rsp_valid stays 0.
- **Contention:** ifu and lsu valid together in IDLE → LSU granted first (store wstrb 0xF, wdata 0xDEADBEEF appear on mem_req_*); IFU granted on the next IDLE.
- **Starvation, STARVE_LIMIT = 4:** both valid continuously → grant order LSU, LSU, LSU, LSU, IFU, LSU…; starve_cnt reaches 4 then clears.
- **Flush:** IFU owner in RSP, ifu_flush pulse, then rsp 0xABCD → ifu_rsp_valid stays 0, FSM returns to IDLE. A new IFU request accepted afterward returns its data normally.
- **Backpressure and reset:** mem_req_ready low for 5 cycles → mem_req fields stable, mem_req_valid held. Assert rst during RSP → all outputs 0 immediately; a later mem_rsp_valid produces no rsp pulse.
- **Error passthrough:** LSU load with mem_rsp_err = 1 → lsu_rsp_valid = 1 and lsu_rsp_err = 1 in the same cycle.
